// File: rtl/conv_mul_pipe.sv
// rtl/conv_mul_pipe.sv - pipelined multiplier with optional per-beat multiply-accumulate
//
// Ports:
//   ap_clk, ap_rst_n          clock, synchronous active-low reset
//   in_valid/in_ready         input beat handshake
//   in_a, in_b                operands (signedness per A_SIGNED/B_SIGNED)
//   in_acc, in_last           beat belongs to an accumulation run / closes the run
//   out_valid/out_ready       result handshake
//   out_p, out_last           product or accumulated sum, last flag of emitting beat
module conv_mul_pipe #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 14,
    parameter int P_WIDTH   = 21,
    parameter int NUM_STAGE = 3,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 0
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] in_a,
    input  logic [B_WIDTH-1:0] in_b,
    input  logic               in_acc,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] out_p,
    output logic               out_last
);

    localparam int W = A_WIDTH + B_WIDTH;
    // Multiply at the wider of the full product and the result so that,
    // when P_WIDTH > W, the operand extension also extends the product.
    localparam int M = (P_WIDTH > W) ? P_WIDTH : W;

    logic               adv;
    logic [M-1:0]       a_m;
    logic [M-1:0]       b_m;
    logic [P_WIDTH-1:0] prod_p;
    logic               a_sx;
    logic               b_sx;

    logic               feed_valid;
    logic [P_WIDTH-1:0] feed_p;
    logic               feed_acc;
    logic               feed_last;
    logic [P_WIDTH-1:0] acc_q;

    // Whole pipeline moves in lockstep; only a stalled full output register
    // freezes it.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && ap_rst_n;

    always_comb begin
        a_sx   = (A_SIGNED != 0) && in_a[A_WIDTH-1];
        b_sx   = (B_SIGNED != 0) && in_b[B_WIDTH-1];
        a_m    = {{(M-A_WIDTH){a_sx}}, in_a};
        b_m    = {{(M-B_WIDTH){b_sx}}, in_b};
        prod_p = P_WIDTH'(a_m * b_m);
    end

    generate
        if (NUM_STAGE > 1) begin : g_pipe
            localparam int D = NUM_STAGE - 1;

            logic [P_WIDTH-1:0] s_p [D];
            logic [D-1:0]       s_valid;
            logic [D-1:0]       s_acc;
            logic [D-1:0]       s_last;

            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    s_valid <= '0;
                    s_acc   <= '0;
                    s_last  <= '0;
                    for (int i = 0; i < D; i++) begin
                        s_p[i] <= '0;
                    end
                end else if (adv) begin
                    s_valid[0] <= in_valid;
                    s_p[0]     <= prod_p;
                    s_acc[0]   <= in_acc;
                    s_last[0]  <= in_last;
                    for (int i = 1; i < D; i++) begin
                        s_valid[i] <= s_valid[i-1];
                        s_p[i]     <= s_p[i-1];
                        s_acc[i]   <= s_acc[i-1];
                        s_last[i]  <= s_last[i-1];
                    end
                end
            end

            assign feed_valid = s_valid[D-1];
            assign feed_p     = s_p[D-1];
            assign feed_acc   = s_acc[D-1];
            assign feed_last  = s_last[D-1];
        end else begin : g_direct
            // Single stage: the product lands straight in the output register.
            assign feed_valid = in_valid;
            assign feed_p     = prod_p;
            assign feed_acc   = in_acc;
            assign feed_last  = in_last;
        end
    endgenerate

    // Output register and accumulator. Plain beats bypass the accumulator,
    // so they can interleave with an open run without disturbing it.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_last  <= 1'b0;
            acc_q     <= '0;
        end else if (adv) begin
            if (feed_valid && (!feed_acc || feed_last)) begin
                out_valid <= 1'b1;
                out_p     <= feed_acc ? (acc_q + feed_p) : feed_p;
                out_last  <= feed_last;
                if (feed_acc) begin
                    acc_q <= '0;
                end
            end else begin
                out_valid <= 1'b0;
                if (feed_valid) begin
                    acc_q <= acc_q + feed_p;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mul_pipe.sv
// tb/tb_conv_mul_pipe.sv - scoreboard bench for conv_mul_pipe
module tb_conv_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [13:0] in_b;
    logic        in_acc;
    logic        in_last;
    logic        out_ready;

    logic        r0, v0, l0;
    logic [20:0] p0;
    logic        rs, vs, ls;
    logic [20:0] ps;
    logic        r1, v1, l1;
    logic [20:0] p1;
    logic        r6, v6, l6;
    logic [20:0] p6;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [20:0] p;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    logic [20:0] model_acc = '0;

    conv_mul_pipe u0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(r0),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_last(in_last),
        .out_valid(v0), .out_ready(out_ready), .out_p(p0), .out_last(l0)
    );

    conv_mul_pipe #(.A_SIGNED(1)) us (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rs),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_last(in_last),
        .out_valid(vs), .out_ready(out_ready), .out_p(ps), .out_last(ls)
    );

    conv_mul_pipe #(.NUM_STAGE(1)) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(r1),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_last(in_last),
        .out_valid(v1), .out_ready(out_ready), .out_p(p1), .out_last(l1)
    );

    conv_mul_pipe #(.NUM_STAGE(6)) u6 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(r6),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_last(in_last),
        .out_valid(v6), .out_ready(out_ready), .out_p(p6), .out_last(l6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] mprod(input int a, input int b, input bit a_signed);
        longint av;
        longint pr;
        av = (a_signed && a >= 128) ? longint'(a - 256) : longint'(a);
        pr = av * longint'(b);
        return pr[20:0];
    endfunction

    task automatic model_push(input int a, input int b, input bit acc, input bit last);
        logic [20:0] p;
        p = mprod(a, b, 1'b0);
        if (!acc) begin
            sb_q.push_back('{p, last});
        end else if (!last) begin
            model_acc = model_acc + p;
        end else begin
            sb_q.push_back('{model_acc + p, 1'b1});
            model_acc = '0;
        end
    endtask

    // Present a beat and hold it until u0 accepts it; returns #1 after the
    // accepting edge.
    task automatic send(input int a, input int b, input bit acc, input bit last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_a     = 8'(a);
        in_b     = 14'(b);
        in_acc   = acc;
        in_last  = last;
        @(negedge clk);
        while (!r0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 64'd0, 64'd1);
        model_push(a, b, acc, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Output monitor for u0: scoreboard pop on every handshake, plus
    // stall-stability checks while backpressured.
    logic        prev_stall = 1'b0;
    logic [20:0] prev_p;
    logic        prev_l;

    always @(negedge clk) begin
        if (rst_n) begin
            if (v0 && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_extra_output", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_out_p", 64'(p0), 64'(e.p));
                    check("sb_out_last", 64'(l0), 64'(e.last));
                end
            end
            if (v0 && !out_ready) begin
                check("stall_in_ready", 64'(r0), 64'd0);
                if (prev_stall) begin
                    check("stall_p_stable", 64'(p0), 64'(prev_p));
                    check("stall_last_stable", 64'(l0), 64'(prev_l));
                end
            end
            prev_stall = v0 && !out_ready;
            prev_p     = p0;
            prev_l     = l0;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat0, lat1, lat6;
        logic [20:0] e1;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(v0), 64'd0);
        check("rst_out_p", 64'(p0), 64'd0);
        check("rst_out_last", 64'(l0), 64'd0);
        check("rst_in_ready", 64'(r0), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency and product for depth 3, 1 and 6.
        e1 = mprod(255, 16383, 1'b0);
        check("model_max_prod", 64'(e1), 64'h1FBF01);
        lat0 = 0; lat1 = 0; lat6 = 0;
        send(255, 16383, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            if (v0 && lat0 == 0) begin lat0 = k; check("ns3_out_p", 64'(p0), 64'(e1)); end
            if (v1 && lat1 == 0) begin lat1 = k; check("ns1_out_p", 64'(p1), 64'(e1)); end
            if (v6 && lat6 == 0) begin lat6 = k; check("ns6_out_p", 64'(p6), 64'(e1)); end
            @(posedge clk);
            #1;
        end
        check("ns3_latency", 64'(lat0), 64'd3);
        check("ns1_latency", 64'(lat1), 64'd1);
        check("ns6_latency", 64'(lat6), 64'd6);

        // Signed vs unsigned a.
        send(255, 100, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        check("signed_valid", 64'(vs), 64'd1);
        check("signed_out_p", 64'(ps), 64'(mprod(255, 100, 1'b1)));
        check("signed_model", 64'(mprod(255, 100, 1'b1)), 64'h1FFF9C);
        repeat (4) @(posedge clk);
        #1;

        // Accumulation runs, interleaved plain beat and wrap-around.
        send(3, 4, 1'b1, 1'b0);
        send(5, 6, 1'b1, 1'b0);
        send(7, 8, 1'b1, 1'b1);
        send(2, 2, 1'b1, 1'b1);
        send(3, 4, 1'b1, 1'b0);
        send(9, 9, 1'b0, 1'b1);
        send(5, 6, 1'b1, 1'b0);
        send(7, 8, 1'b1, 1'b1);
        send(255, 16383, 1'b1, 1'b0);
        send(255, 16383, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;

        // Back-to-back burst with out_ready low for cycles 4..8.
        fork
            begin
                for (int i = 0; i < 10; i++) send(i, i + 1, 1'b0, 1'b0);
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = !(c >= 4 && c <= 8);
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("burst_drained", 64'(sb_q.size()), 64'd0);

        // Reset in the middle of an accumulation run.
        send(10, 10, 1'b1, 1'b0);
        send(10, 10, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_low_in_ready", 64'(r0), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(v0), 64'd0);
        check("midrst_out_p", 64'(p0), 64'd0);
        check("midrst_out_last", 64'(l0), 64'd0);
        sb_q.delete();
        model_acc = '0;
        rst_n = 1'b1;
        send(1, 1, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_mul_pipe.md
# conv_mul_pipe

Parametrised, pipelined multiplier with optional multiply-accumulate for the convolution datapath. It replaces the fixed-width, single-stage 8×14 unsigned product with four additions:
- configurable operand widths and signedness;
- a configurable register pipeline;
- valid/ready flow control with backpressure;
- a per-beat accumulate mode that reduces a run of products to one result.

It sits between the line-buffer/window fetch and the output packing stage of the conv core.

## Interface
Parameters:
- A_WIDTH, 8, width of operand a
- B_WIDTH, 14, width of operand b
- P_WIDTH, 21, result width; product/accumulator kept modulo 2^P_WIDTH (low bits)
- NUM_STAGE, 3, pipeline depth 1..6 = accept-to-out_valid latency in cycles with no stall
- A_SIGNED, 0, 1 = a is two's complement, 0 = unsigned
- B_SIGNED, 0, 1 = b is two's complement, 0 = unsigned

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst_n  in  1  reset; one clock, synchronous and active-low
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts the beat this cycle
- in_a  in  A_WIDTH  operand a
- in_b  in  B_WIDTH  operand b
- in_acc  in  1  beat belongs to an accumulation run
- in_last  in  1  closes the current accumulation run; also passed through in plain mode
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_p  out  P_WIDTH  product or accumulated sum
- out_last  out  1  in_last of the emitting beat

## Operation
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- Sign extension: a and b are extended to A_WIDTH+B_WIDTH per A_SIGNED/B_SIGNED.
- Product: the full-width product is truncated to its low P_WIDTH bits. If P_WIDTH exceeds A_WIDTH+B_WIDTH, the product is sign-extended when either operand is signed, otherwise zero-extended.
- Pipeline contents: each stage carries a valid bit, data, acc and last. The product is registered at stage 1. Stages 2..NUM_STAGE-1 are pure delay. Stage NUM_STAGE is the output register.
- Global advance: adv = !out_valid || out_ready. When adv = 0, every stage holds and in_ready = 0.
- in_ready = adv && ap_rst_n, combinational from out_valid/out_ready.
- Final-stage behaviour for a beat reaching it while adv is high:
  - acc = 0: out_p = product, out_valid = 1. The accumulator is untouched.
  - acc = 1, last = 0: accumulator ← accumulator + product (mod 2^P_WIDTH), no output.
  - acc = 1, last = 1: out_p = accumulator + product, out_valid = 1, accumulator ← 0.
- Accumulator start: after reset or a completed run, the accumulator is 0, so a run needs no explicit clear.
- Interleaving: a plain beat (acc = 0) inside an open run is emitted normally and leaves the run's partial sum intact.
- Bubbles: stages advance even when empty, so bubbles collapse only at the output register. No bypass.
- Overflow: not flagged. Wrap-around modulo 2^P_WIDTH is required behaviour.

## Timing
- Reset (ap_rst_n low at a rising edge) clears:
  - all stage valid bits, data and last flags;
  - out_valid = 0, out_p = 0, out_last = 0;
  - the accumulator.
  in_ready = 0 while ap_rst_n is low.
- Reset mid-operation discards all in-flight beats and any partial accumulation. The first beat after reset release starts from an accumulator of 0.
- Latency: a beat accepted at edge N appears at out_valid after edge N+NUM_STAGE-1, i.e. NUM_STAGE cycles from acceptance, if out_ready stays high. An accumulate beat with last = 0 produces no output.
- Throughput: one beat per cycle when out_ready is held high.
- Output stability: while out_valid && !out_ready, out_p and out_last are stable and no input is accepted.
- Simultaneous accept and emit: in the same cycle, with out_ready high, a new beat is accepted and the output register reloads. There is no dead cycle.
- NUM_STAGE = 1: the product is computed combinationally into the output register. Same handshake rules.

## Test plan
- Unsigned, defaults: a = 255, b = 16383, in_acc = 0, out_ready = 1 -> out_p = 0x1FBF01 (2080513, low 21 bits of 0x3FBF01), out_valid high exactly 3 cycles after acceptance.
- A_SIGNED = 1: a = 0xFF (-1), b = 100 -> out_p = 0x1FFF9C (-100 mod 2^21). With A_SIGNED = 0, same inputs -> out_p = 25500.
- Accumulate: beats (3,4,acc,!last), (5,6,acc,!last), (7,8,acc,last) -> one output, out_p = 98, out_last = 1. Next run (2,2,acc,last) -> out_p = 4.
- Backpressure: 10 back-to-back beats a = i, b = i+1 with out_ready low for cycles 4..8 -> in_ready low during those cycles, all 10 products i·(i+1) emitted in order, none lost or duplicated, out_p stable while stalled.
- Reset mid-run: two accumulate beats (10,10), (10,10), then ap_rst_n low 1 cycle -> all outputs 0 at the next edge. Then (1,1,acc,last) -> out_p = 1, not 201.
- NUM_STAGE = 1 and NUM_STAGE = 6 regressions of scenario 1 -> latencies of 1 and 6 cycles, same out_p.
